rl11_dma: RTL and testbench

- Unibus NPR (DMA) master sitting directly downstream of the RL01/2 register interface.
- ARM software decodes an RL command from the controller registers. For a transfer, it loads or unloads a 128-word sector buffer in this block and starts a burst.
- The block then arbitrates for the Unibus and moves words between the buffer and PDP memory. It reports completion or non-existent memory (NXM) back to the ARM.

---
 rtl/rl11_dma_if.sv | 28 ++
 rtl/rl11_dma.sv | 173 +++++++++++++++++
 tb/tb_rl11_dma.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rl11_dma_if.sv
// Unibus NPR signal bundle between the RL11 DMA master and the bus.
// master: DMA side (drives NPR/SACK/BBSY/A/C/D/MSYN); slave: bus side.
interface rl11_dma_if;
    logic        init_in_h;
    logic        npr_out_h;
    logic        npg_in_h;
    logic        sack_out_h;
    logic        bbsy_in_h;
    logic        bbsy_out_h;
    logic [17:0] a_out_h;
    logic [1:0]  c_out_h;
    logic [15:0] d_out_h;
    logic        msyn_out_h;
    logic        ssyn_in_h;
    logic [15:0] d_in_h;

    modport master (
        input  init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h,
        output npr_out_h, sack_out_h, bbsy_out_h,
        output a_out_h, c_out_h, d_out_h, msyn_out_h
    );

    modport slave (
        output init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h,
        input  npr_out_h, sack_out_h, bbsy_out_h,
        input  a_out_h, c_out_h, d_out_h, msyn_out_h
    );
endinterface

// File: rtl/rl11_dma.sv
// RL11 Unibus NPR master: 128-word sector buffer, ARM register window
// (armwrite/armraddr/armwaddr/armwdata/armrdata/armintrq) and the
// Unibus NPR/DATI/DATO sequencer on the ub interface. CLOCK, RESET sync.
module rl11_dma #(
    parameter int MSYNDLY = 15,
    parameter int TIMEOUT = 1000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [2:0]  armraddr,
    input  logic [2:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        armintrq,
    rl11_dma_if.master  ub
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_GRANT, S_SETUP, S_MSYN, S_WAITS, S_RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_dir;
    logic        r_nxm;
    logic        r_done;
    logic [7:0]  r_cnt;
    logic [17:0] r_addr;
    logic [6:0]  r_ptr;
    logic [6:0]  r_bufidx;
    logic [15:0] r_tmr;
    logic [15:0] r_buf [128];

    logic        w_busy;
    logic        w_start;
    logic        w_wr2;
    logic        w_tmr_hit;
    logic        w_drive;
    logic        w_adv;
    logic        w_latch;
    logic        w_nxm;
    logic        w_fin;
    logic [7:0]  w_cm1;
    logic        w_unused;

    assign w_busy  = (r_state != S_IDLE);
    assign w_start = armwrite && (armwaddr == 3'd1) && armwdata[31] && !w_busy;
    assign w_wr2   = armwrite && (armwaddr == 3'd2);
    assign w_cm1   = r_cnt - 8'd1;
    assign w_unused = ^{armwdata[29:25], armwdata[23], armwdata[0], w_cm1[7]};

    // One timer serves both the MSYN deskew delay and the SSYN timeout.
    assign w_tmr_hit = (r_state == S_MSYN) ? (r_tmr == 16'(TIMEOUT - 1))
                                           : (r_tmr == 16'(MSYNDLY - 1));

    always_ff @(posedge CLOCK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_adv   = 1'b0;
        w_latch = 1'b0;
        w_nxm   = 1'b0;
        w_fin   = 1'b0;
        if (ub.init_in_h) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:  if (w_start) w_next = S_REQ;
                S_REQ:   if (ub.npg_in_h) w_next = S_GRANT;
                S_GRANT: begin
                    if (!ub.bbsy_in_h && !ub.ssyn_in_h && !ub.npg_in_h)
                        w_next = S_SETUP;
                end
                S_SETUP: if (w_tmr_hit) w_next = S_MSYN;
                S_MSYN: begin
                    if (ub.ssyn_in_h) begin
                        w_latch = !r_dir;
                        w_next  = S_WAITS;
                    end else if (w_tmr_hit) begin
                        w_nxm  = 1'b1;
                        w_next = S_RELEASE;
                    end
                end
                S_WAITS: begin
                    if (!ub.ssyn_in_h) begin
                        w_adv  = 1'b1;
                        w_next = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (r_cnt == 8'd0 || r_nxm) begin
                        w_fin  = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_REQ;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Bus is owned from SETUP through WAITS; lines drop in RELEASE.
    assign w_drive       = (r_state == S_SETUP) || (r_state == S_MSYN) ||
                           (r_state == S_WAITS);
    assign ub.npr_out_h  = (r_state == S_REQ);
    assign ub.sack_out_h = (r_state == S_GRANT);
    assign ub.bbsy_out_h = w_drive;
    assign ub.msyn_out_h = (r_state == S_MSYN);
    assign ub.a_out_h    = w_drive ? r_addr : 18'd0;
    assign ub.c_out_h    = (w_drive && r_dir) ? 2'b10 : 2'b00;
    assign ub.d_out_h    = (w_drive && r_dir) ? r_buf[r_ptr] : 16'd0;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_dir    <= 1'b0;
            r_nxm    <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= 8'd0;
            r_addr   <= 18'd0;
            r_ptr    <= 7'd0;
            r_bufidx <= 7'd0;
            r_tmr    <= 16'd0;
        end else begin
            r_tmr <= (w_next != r_state) ? 16'd0 : r_tmr + 16'd1;
            if (w_start) begin
                r_dir  <= armwdata[30];
                r_cnt  <= {1'b0, armwdata[24:18]} + 8'd1;
                r_addr <= {armwdata[17:1], 1'b0};
                r_ptr  <= 7'd0;
                r_done <= 1'b0;
                r_nxm  <= 1'b0;
            end
            if (w_adv) begin
                r_ptr  <= r_ptr + 7'd1;
                r_addr <= r_addr + 18'd2;
                r_cnt  <= r_cnt - 8'd1;
            end
            if (w_nxm) r_nxm <= 1'b1;
            if (w_fin) r_done <= 1'b1;
            if (ub.init_in_h) begin
                r_nxm  <= 1'b0;
                r_done <= 1'b0;
            end
            if (w_wr2) begin
                r_bufidx <= armwdata[31] ? armwdata[22:16] + 7'd1
                                         : armwdata[22:16];
            end
        end
    end

    // ARM write lands after the DATI latch so it wins on a collision.
    always_ff @(posedge CLOCK) begin
        if (w_latch) r_buf[r_ptr] <= ub.d_in_h;
        if (w_wr2 && armwdata[31]) r_buf[armwdata[22:16]] <= armwdata[15:0];
    end

    always_comb begin
        armrdata = 32'hDEADBEEF;
        unique case (armraddr)
            3'd0: armrdata = 32'h444D1001;
            3'd1: armrdata = {w_busy, r_dir, r_nxm, r_done, 3'b000,
                              w_cm1[6:0], r_addr};
            3'd2: armrdata = {9'd0, r_bufidx, r_buf[r_bufidx]};
            default: armrdata = 32'hDEADBEEF;
        endcase
    end

    assign armintrq = r_done && !w_busy;
endmodule

// File: tb/tb_rl11_dma.sv
// Self-checking bench for rl11_dma: register vectors, directed bursts,
// random bursts against a word-level transfer model, NXM/INIT/busy cases.
module tb_rl11_dma;
    localparam int MSYNDLY = 15;
    localparam int TIMEOUT = 1000;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        armwrite = 1'b0;
    logic [2:0]  armraddr = 3'd0;
    logic [2:0]  armwaddr = 3'd0;
    logic [31:0] armwdata = 32'd0;
    logic [31:0] armrdata;
    logic        armintrq;

    rl11_dma_if ub ();

    rl11_dma #(.MSYNDLY(MSYNDLY), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .armwrite(armwrite), .armraddr(armraddr),
        .armwaddr(armwaddr), .armwdata(armwdata),
        .armrdata(armrdata), .armintrq(armintrq),
        .ub(ub)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [17:0] a;
        logic [1:0]  c;
        logic [15:0] d;
    } txn_t;

    typedef struct {
        bit          wr;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] mask;
        logic [31:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    txn_t got_q[$];
    txn_t exp_q[$];
    logic [15:0] mem [logic [17:0]];
    logic [15:0] mbuf [128];
    bit bbsy_hold = 1'b0;
    int msyn_run = 0;
    int last_msyn = 0;
    int npr_rises = 0;
    bit cur_dir;
    logic [17:0] cur_a;
    int cur_n;
    vec_t vt[12];

    function automatic bit mapped(input logic [17:0] a);
        return !(a >= 18'o760000 && a < 18'o770000);
    endfunction

    function automatic logic [15:0] mem_rd(input logic [17:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'o52525;
    endfunction

    function automatic logic [39:0] bus_out();
        return {ub.npr_out_h, ub.sack_out_h, ub.bbsy_out_h, ub.msyn_out_h,
                ub.c_out_h, ub.a_out_h, ub.d_out_h};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
        armwaddr = a;
        armwdata = d;
        armwrite = 1'b1;
        @(negedge CLOCK);
        armwrite = 1'b0;
    endtask

    task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
        armraddr = a;
        #1;
        d = armrdata;
    endtask

    task automatic load_buf(input int n);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = 16'($urandom);
            mbuf[i] = v;
            arm_wr(3'd2, {1'b1, 8'd0, 7'(i), v});
        end
    endtask

    task automatic chk_buf(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            arm_wr(3'd2, {9'd0, 7'(i), 16'd0});
            arm_rd(3'd2, r);
            chk("bufread", r, {9'd0, 7'(i), mbuf[i]});
        end
    endtask

    // Expected transfer list: word i goes to addr+2i (18-bit wrap).
    task automatic start_burst(input bit dir, input logic [17:0] a,
                               input int n);
        txn_t t;
        exp_q.delete();
        got_q.delete();
        npr_rises = 0;
        cur_dir = dir;
        cur_a = a;
        cur_n = n;
        for (int i = 0; i < n; i++) begin
            t.a = a + 18'(2 * i);
            t.c = dir ? 2'b10 : 2'b00;
            t.d = dir ? mbuf[i] : mem_rd(t.a);
            exp_q.push_back(t);
        end
        arm_wr(3'd1, {1'b1, dir, 5'd0, 7'(n - 1), a});
    endtask

    task automatic finish_burst(input string nm, input int budget);
        int k;
        logic [31:0] r;
        k = 0;
        while (!armintrq && k < budget) begin
            @(negedge CLOCK);
            k++;
        end
        chk({nm, " done"}, armintrq, 1);
        chk({nm, " words"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({nm, " txn"}, {got_q[i].a, got_q[i].c, got_q[i].d},
                {exp_q[i].a, exp_q[i].c, exp_q[i].d});
        if (!cur_dir)
            for (int i = 0; i < cur_n; i++) mbuf[i] = exp_q[i].d;
        chk({nm, " npr"}, npr_rises, cur_n);
        arm_rd(3'd1, r);
        chk({nm, " status"}, r, {1'b0, cur_dir, 1'b0, 1'b1, 3'd0, 7'h7f,
                                 cur_a + 18'(2 * cur_n)});
        chk({nm, " idle"}, bus_out(), 0);
    endtask

    // Bus-side responder: grants NPR, answers SSYN 5 clocks into MSYN.
    initial begin
        int dly;
        bit prev_npr;
        txn_t t;
        dly = 0;
        prev_npr = 1'b0;
        ub.npg_in_h  = 1'b0;
        ub.bbsy_in_h = 1'b0;
        ub.ssyn_in_h = 1'b0;
        ub.d_in_h    = 16'd0;
        forever begin
            @(negedge CLOCK);
            if (ub.npr_out_h && !prev_npr) npr_rises++;
            prev_npr = ub.npr_out_h;
            ub.npg_in_h  = ub.npr_out_h;
            ub.bbsy_in_h = bbsy_hold;
            if (ub.msyn_out_h) begin
                msyn_run++;
                if (!ub.ssyn_in_h && mapped(ub.a_out_h)) begin
                    dly++;
                    if (dly == 5) begin
                        t.a = ub.a_out_h;
                        t.c = ub.c_out_h;
                        if (ub.c_out_h == 2'b10) begin
                            t.d = ub.d_out_h;
                            mem[t.a] = t.d;
                        end else begin
                            t.d = mem_rd(t.a);
                            ub.d_in_h = t.d;
                        end
                        got_q.push_back(t);
                        ub.ssyn_in_h = 1'b1;
                    end
                end
            end else begin
                if (msyn_run != 0) last_msyn = msyn_run;
                msyn_run = 0;
                dly = 0;
                ub.ssyn_in_h = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] r;
        int k;
        bit d;
        int n;
        logic [17:0] a;

        ub.init_in_h = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);

        arm_rd(3'd1, r);
        chk("reset status", r, 32'h01FC0000);
        chk("reset intrq", armintrq, 0);
        chk("reset bus", bus_out(), 0);

        vt[0]  = '{0, 3'd0, 32'h0,        3'd0, 32'hFFFFFFFF, 32'h444D1001};
        vt[1]  = '{0, 3'd0, 32'h0,        3'd3, 32'hFFFFFFFF, 32'hDEADBEEF};
        vt[2]  = '{0, 3'd0, 32'h0,        3'd7, 32'hFFFFFFFF, 32'hDEADBEEF};
        vt[3]  = '{1, 3'd2, 32'h8005ABCD, 3'd2, 32'h007F0000, 32'h00060000};
        vt[4]  = '{1, 3'd2, 32'h80061234, 3'd2, 32'h007F0000, 32'h00070000};
        vt[5]  = '{1, 3'd2, 32'h00050000, 3'd2, 32'hFFFFFFFF, 32'h0005ABCD};
        vt[6]  = '{1, 3'd2, 32'h00060000, 3'd2, 32'hFFFFFFFF, 32'h00061234};
        vt[7]  = '{1, 3'd2, 32'h807F5555, 3'd2, 32'h007F0000, 32'h00000000};
        vt[8]  = '{1, 3'd2, 32'h007F0000, 3'd2, 32'hFFFFFFFF, 32'h007F5555};
        vt[9]  = '{1, 3'd5, 32'hFFFFFFFF, 3'd1, 32'hFFFFFFFF, 32'h01FC0000};
        vt[10] = '{1, 3'd1, 32'h7FFFFFFF, 3'd1, 32'hFFFFFFFF, 32'h01FC0000};
        vt[11] = '{1, 3'd3, 32'h80000000, 3'd2, 32'hFFFFFFFF, 32'h007F5555};
        for (int i = 0; i < 12; i++) begin
            if (vt[i].wr) arm_wr(vt[i].wa, vt[i].wd);
            arm_rd(vt[i].ra, r);
            chk($sformatf("vec%0d", i), r & vt[i].mask, vt[i].exp);
        end

        for (int i = 0; i < 4; i++) begin
            mbuf[i] = 16'(i + 1);
            arm_wr(3'd2, {1'b1, 8'd0, 7'(i), 16'(i + 1)});
        end
        start_burst(1'b1, 18'o001000, 4);
        finish_burst("dato4", 400);

        mem[18'o002000] = 16'o123456;
        mem[18'o002002] = 16'o654321;
        start_burst(1'b0, 18'o002000, 2);
        finish_burst("dati2", 300);
        chk_buf(2);

        load_buf(2);
        start_burst(1'b1, 18'o777776, 2);
        finish_burst("wrap", 300);

        for (int j = 0; j < 6; j++) begin
            d = 1'($urandom);
            n = int'($urandom_range(1, 8));
            a = 18'($urandom_range(0, 32'o177777) * 2);
            if (d) load_buf(n);
            start_burst(d, a, n);
            finish_burst("random", n * 60 + 100);
            if (!d) chk_buf(n);
        end

        load_buf(1);
        got_q.delete();
        arm_wr(3'd1, {1'b1, 1'b1, 5'd0, 7'd0, 18'o760000});
        k = 0;
        while (!armintrq && k < 1500) begin
            @(negedge CLOCK);
            k++;
        end
        chk("nxm done", armintrq, 1);
        chk("nxm msyn len", last_msyn, TIMEOUT);
        arm_rd(3'd1, r);
        chk("nxm status", r, {4'b0111, 3'd0, 7'd0, 18'o760000});
        chk("nxm bus", bus_out(), 0);
        chk("nxm words", got_q.size(), 0);

        arm_wr(3'd1, {1'b1, 1'b1, 5'd0, 7'd2, 18'o760000});
        k = 0;
        while (!ub.msyn_out_h && k < 200) begin
            @(negedge CLOCK);
            k++;
        end
        chk("init msyn seen", ub.msyn_out_h, 1);
        repeat (3) @(negedge CLOCK);
        ub.init_in_h = 1'b1;
        @(negedge CLOCK);
        ub.init_in_h = 1'b0;
        chk("init bus", bus_out(), 0);
        arm_rd(3'd1, r);
        chk("init busy/done", {r[31], r[28], armintrq}, 0);
        load_buf(1);
        start_burst(1'b1, 18'o004000, 1);
        finish_burst("after init", 200);

        bbsy_hold = 1'b1;
        load_buf(2);
        start_burst(1'b1, 18'o003000, 2);
        k = 0;
        while (!ub.sack_out_h && k < 50) begin
            @(negedge CLOCK);
            k++;
        end
        chk("sack seen", ub.sack_out_h, 1);
        arm_wr(3'd1, {1'b1, 1'b0, 5'd0, 7'd6, 18'o005000});
        arm_rd(3'd1, r);
        chk("busy write ignored", {r[31:30], r[24:0]},
            {2'b11, 7'd1, 18'o003000});
        repeat (10) @(negedge CLOCK);
        chk("grant holds", {ub.sack_out_h, ub.bbsy_out_h}, 2'b10);
        bbsy_hold = 1'b0;
        finish_burst("bbsy", 300);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
